// File: rtl/node_pkg.sv
// Shared types and constants for the node readout chain.
package node_pkg;

    localparam int VAL_W_DEF = 32;
    localparam int POS_W_DEF = 32;
    localparam int SEQ_W     = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/node_snapshot_unit_if.sv
// Snapshot output stream from node_snapshot_unit to the host/logging side.
interface node_snapshot_unit_if #(
    parameter int NUM_NODES = 3,
    parameter int VAL_W     = 32,
    parameter int POS_W     = 32
) ();
    import node_pkg::*;

    localparam int IDX_W = $clog2(NUM_NODES);

    // A beat transfers on every cycle where out_valid && out_ready; while
    // out_valid is high and out_ready low, all out_* hold stable, and
    // out_valid never drops before the out_last beat has transferred.
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [VAL_W-1:0] out_val;
    logic [POS_W-1:0] out_pos;
    logic             out_last;
    logic [SEQ_W-1:0] out_seq;
    logic             overrun;

    modport master (
        output out_valid, out_index, out_val, out_pos, out_last, out_seq, overrun,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_index, out_val, out_pos, out_last, out_seq, overrun,
        output out_ready
    );

endinterface

// File: rtl/snapshot_bank.sv
// One NUM_NODES-entry capture bank: parallel load of both buses, indexed read.
module snapshot_bank #(
    parameter int NUM_NODES = 3,
    parameter int VAL_W     = 32,
    parameter int POS_W     = 32,
    parameter int IDX_W     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [NUM_NODES*VAL_W-1:0] val_bus,
    input  logic [NUM_NODES*POS_W-1:0] pos_bus,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [VAL_W-1:0]           rd_val,
    output logic [POS_W-1:0]           rd_pos
);

    logic [VAL_W-1:0] vals [NUM_NODES];
    logic [POS_W-1:0] poss [NUM_NODES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                vals[i] <= '0;
                poss[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                vals[i] <= val_bus[i*VAL_W +: VAL_W];
                poss[i] <= pos_bus[i*POS_W +: POS_W];
            end
        end
    end

    // Out-of-range indices (non power-of-two NUM_NODES) read as zero.
    always_comb begin
        rd_val = '0;
        rd_pos = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_val = vals[i];
                rd_pos = poss[i];
            end
        end
    end

endmodule

// File: rtl/node_snapshot_unit.sv
// Captures all node outputs on a decimated timestep and streams them one node
// per beat. NODE_SNAPSHOT_DOUBLE_BUFFER_EN adds a second bank for a pending snapshot.
module node_snapshot_unit
    import node_pkg::*;
#(
    parameter int NUM_NODES = 3,
    parameter int VAL_W     = VAL_W_DEF,
    parameter int POS_W     = POS_W_DEF,
    parameter int DECIM     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       step_done,
    input  logic [NUM_NODES*VAL_W-1:0] nodeval_bus,
    input  logic [NUM_NODES*POS_W-1:0] nodepos_bus,
    node_snapshot_unit_if.master       snap,
    output state_t                     fsm_state
);

    localparam int IDX_W  = $clog2(NUM_NODES);
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
    localparam int NBANKS = 2;
`else
    localparam int NBANKS = 1;
`endif

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VAL_W-1:0]  val_q, val_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              last_q, last_d;
    logic [SEQ_W-1:0]  oseq_q, oseq_d;
    logic              ovr_q, ovr_d;
    logic [SEQ_W-1:0]  seq_cnt_q, seq_cnt_d;
    logic [DCNT_W-1:0] dcnt_q;
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
    logic              act_q, act_d;
    logic              pend_q, pend_d;
    logic [SEQ_W-1:0]  pend_seq_q, pend_seq_d;
    logic              src;
`endif

    logic              eligible, hs, fin;
    logic [IDX_W-1:0]  idx_inc, rd_idx;
    logic [VAL_W-1:0]  nxt_val;
    logic [POS_W-1:0]  nxt_pos;
    logic [NBANKS-1:0] load;
    logic [VAL_W-1:0]  bank_val [NBANKS];
    logic [POS_W-1:0]  bank_pos [NBANKS];

    assign eligible = step_done && (dcnt_q == '0);
    assign hs       = valid_q && snap.out_ready;
    assign fin      = hs && last_q;
    assign idx_inc  = idx_q + IDX_W'(1);
    // On the last beat the next data is entry 0 of the pending bank.
    assign rd_idx   = last_q ? '0 : idx_inc;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        snapshot_bank #(
            .NUM_NODES(NUM_NODES),
            .VAL_W    (VAL_W),
            .POS_W    (POS_W),
            .IDX_W    (IDX_W)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load[b]),
            .val_bus(nodeval_bus),
            .pos_bus(nodepos_bus),
            .rd_idx (rd_idx),
            .rd_val (bank_val[b]),
            .rd_pos (bank_pos[b])
        );
    end

`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
    assign src     = last_q ? ~act_q : act_q;
    assign nxt_val = bank_val[src];
    assign nxt_pos = bank_pos[src];
`else
    assign nxt_val = bank_val[0];
    assign nxt_pos = bank_pos[0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dcnt_q <= '0;
        end else if (step_done) begin
            dcnt_q <= (dcnt_q == DCNT_W'(DECIM - 1)) ? '0 : dcnt_q + DCNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        val_d     = val_q;
        pos_d     = pos_q;
        last_d    = last_q;
        oseq_d    = oseq_q;
        ovr_d     = ovr_q;
        seq_cnt_d = seq_cnt_q;
        load      = '0;
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
        act_d      = act_q;
        pend_d     = pend_q;
        pend_seq_d = pend_seq_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d   = DRAIN;
                    valid_d   = 1'b1;
                    idx_d     = '0;
                    val_d     = nodeval_bus[VAL_W-1:0];
                    pos_d     = nodepos_bus[POS_W-1:0];
                    last_d    = 1'b0;
                    oseq_d    = seq_cnt_q;
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
                    load[act_q] = 1'b1;
`else
                    load[0] = 1'b1;
`endif
                end
            end
            DRAIN: begin
                if (fin) begin
                    idx_d  = '0;
                    last_d = 1'b0;
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
                    if (pend_q) begin
                        act_d  = ~act_q;
                        val_d  = nxt_val;
                        pos_d  = nxt_pos;
                        oseq_d = pend_seq_q;
                        pend_d = 1'b0;
                        // The bank just finished is free again for a coincident capture.
                        if (eligible) begin
                            load[act_q] = 1'b1;
                            pend_d      = 1'b1;
                            pend_seq_d  = seq_cnt_q;
                            seq_cnt_d   = seq_cnt_q + SEQ_W'(1);
                        end
                    end else
`endif
                    if (eligible) begin
                        val_d     = nodeval_bus[VAL_W-1:0];
                        pos_d     = nodepos_bus[POS_W-1:0];
                        oseq_d    = seq_cnt_q;
                        seq_cnt_d = seq_cnt_q + SEQ_W'(1);
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
                        act_d        = ~act_q;
                        load[~act_q] = 1'b1;
`else
                        load[0] = 1'b1;
`endif
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end else begin
                    if (hs) begin
                        idx_d  = idx_inc;
                        val_d  = nxt_val;
                        pos_d  = nxt_pos;
                        last_d = (idx_inc == IDX_W'(NUM_NODES - 1));
                    end
                    if (eligible) begin
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
                        if (!pend_q) begin
                            load[~act_q] = 1'b1;
                            pend_d       = 1'b1;
                            pend_seq_d   = seq_cnt_q;
                            seq_cnt_d    = seq_cnt_q + SEQ_W'(1);
                        end else begin
                            ovr_d = 1'b1;
                        end
`else
                        ovr_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            val_q     <= '0;
            pos_q     <= '0;
            last_q    <= 1'b0;
            oseq_q    <= '0;
            ovr_q     <= 1'b0;
            seq_cnt_q <= '0;
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
            act_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_seq_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            pos_q     <= pos_d;
            last_q    <= last_d;
            oseq_q    <= oseq_d;
            ovr_q     <= ovr_d;
            seq_cnt_q <= seq_cnt_d;
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_seq_q <= pend_seq_d;
`endif
        end
    end

    assign snap.out_valid = valid_q;
    assign snap.out_index = idx_q;
    assign snap.out_val   = val_q;
    assign snap.out_pos   = pos_q;
    assign snap.out_last  = last_q;
    assign snap.out_seq   = oseq_q;
    assign snap.overrun   = ovr_q;
    assign fsm_state      = state_q;

endmodule

// File: tb/tb_node_snapshot_unit.sv
// Bench for node_snapshot_unit: vector table, directed corner sequences and a
// randomized run against a snapshot-queue reference model.
module tb_node_snapshot_unit;
    import node_pkg::*;

    localparam int NN = 3;
    localparam int VW = 32;
    localparam int PW = 32;
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             step = 1'b0;
    logic             step_d = 1'b0;
    logic [NN*VW-1:0] vbus = '0;
    logic [NN*PW-1:0] pbus = '0;
    logic [NN*VW-1:0] vbus_d = '0;
    logic [NN*PW-1:0] pbus_d = '0;
    state_t           st, st_d;

    node_snapshot_unit_if #(.NUM_NODES(NN), .VAL_W(VW), .POS_W(PW)) sif ();
    node_snapshot_unit_if #(.NUM_NODES(NN), .VAL_W(VW), .POS_W(PW)) sif_d ();

    node_snapshot_unit #(.NUM_NODES(NN), .VAL_W(VW), .POS_W(PW), .DECIM(1)) dut (
        .clk(clk), .rst_n(rst_n), .step_done(step), .nodeval_bus(vbus),
        .nodepos_bus(pbus), .snap(sif), .fsm_state(st)
    );

    node_snapshot_unit #(.NUM_NODES(NN), .VAL_W(VW), .POS_W(PW), .DECIM(4)) dut_d (
        .clk(clk), .rst_n(rst_n), .step_done(step_d), .nodeval_bus(vbus_d),
        .nodepos_bus(pbus_d), .snap(sif_d), .fsm_state(st_d)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    typedef struct packed {
        logic [NN*VW-1:0] vb;
        logic [NN*PW-1:0] pb;
        logic [15:0]      seq;
    } snap_t;

    snap_t       exp_q[$];
    int          mk = 0;
    logic [15:0] mseq = '0;
    logic        movr = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        snap_t s;
        chk("m_valid", 64'(sif.out_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            s = exp_q[0];
            chk("m_index", 64'(sif.out_index), 64'(mk));
            chk("m_val", 64'(sif.out_val), 64'(s.vb[mk*VW +: VW]));
            chk("m_pos", 64'(sif.out_pos), 64'(s.pb[mk*PW +: PW]));
            chk("m_last", 64'(sif.out_last), 64'(mk == NN - 1));
            chk("m_seq", 64'(sif.out_seq), 64'(s.seq));
        end
        chk("m_overrun", 64'(sif.overrun), 64'(movr));
    endtask

    // Advances the model over the coming edge, then samples 1 time unit after it.
    task automatic cycle();
        bit    hs;
        snap_t s;
        if (!rst_n) begin
            exp_q.delete();
            mk   = 0;
            mseq = '0;
            movr = 1'b0;
        end else begin
            hs = (exp_q.size() > 0) && sif.out_ready;
            if (hs) begin
                mk++;
                if (mk == NN) begin
                    exp_q.delete(0);
                    mk = 0;
                end
            end
            if (step) begin
                if (exp_q.size() < CAP) begin
                    s.vb = vbus;
                    s.pb = pbus;
                    s.seq = mseq;
                    exp_q.push_back(s);
                    mseq = mseq + 16'd1;
                end else begin
                    movr = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        model_check();
    endtask

    // ---------------- drivers ----------------
    function automatic logic [NN*VW-1:0] rand_bus();
        logic [NN*VW-1:0] r;
        for (int i = 0; i < NN; i++) r[i*VW +: VW] = $urandom();
        return r;
    endfunction

    task automatic pulse(input logic [NN*VW-1:0] vb, input logic [NN*PW-1:0] pb);
        step = 1'b1;
        vbus = vb;
        pbus = pb;
        cycle();
        step = 1'b0;
        vbus = rand_bus();
        pbus = rand_bus();
    endtask

    task automatic drain_idle();
        sif.out_ready = 1'b1;
        for (int i = 0; i < 4 * NN + 4 && exp_q.size() > 0; i++) cycle();
        chk("drain_idle", 64'(sif.out_valid), 64'(0));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, 64'(sif.out_valid), 64'(0));
        chk({tag, "_index"}, 64'(sif.out_index), 64'(0));
        chk({tag, "_val"}, 64'(sif.out_val), 64'(0));
        chk({tag, "_pos"}, 64'(sif.out_pos), 64'(0));
        chk({tag, "_last"}, 64'(sif.out_last), 64'(0));
        chk({tag, "_seq"}, 64'(sif.out_seq), 64'(0));
        chk({tag, "_overrun"}, 64'(sif.overrun), 64'(0));
        chk({tag, "_state"}, 64'(st), 64'(IDLE));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NN*VW-1:0] vb;
        logic [NN*PW-1:0] pb;
        int               stall;
        logic [15:0]      exp_seq;
    } vec_t;

    vec_t tbl[4];

    logic [NN*VW-1:0] va, vb2, vc;
    logic [NN*PW-1:0] pa, pb2, pc;
    logic [VW-1:0]    got_val[$];
    logic [15:0]      got_seq[$];

    initial begin
        tbl[0].vb = {32'h30, 32'h20, 32'h10};
        tbl[0].pb = {32'd3, 32'd2, 32'd1};
        tbl[0].stall = 0;
        tbl[0].exp_seq = 16'd0;
        tbl[1].vb = {32'hC3, 32'hB2, 32'hA1};
        tbl[1].pb = {32'd30, 32'd20, 32'd10};
        tbl[1].stall = 5;
        tbl[1].exp_seq = 16'd1;
        tbl[2].vb = {32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
        tbl[2].pb = {32'h1, 32'hFFFF_FFFF, 32'h0};
        tbl[2].stall = 2;
        tbl[2].exp_seq = 16'd2;
        tbl[3].vb = {32'hDEAD_BEEF, 32'h1234_5678, 32'h0BAD_F00D};
        tbl[3].pb = {32'd7, 32'd8, 32'd9};
        tbl[3].stall = 0;
        tbl[3].exp_seq = 16'd3;

        sif.out_ready = 1'b1;
        sif_d.out_ready = 1'b1;

        rst_n = 1'b0;
        cycle();
        cycle();
        chk_reset_values("reset");
        rst_n = 1'b1;
        cycle();

        for (int t = 0; t < 4; t++) begin
            sif.out_ready = (tbl[t].stall == 0);
            pulse(tbl[t].vb, tbl[t].pb);
            for (int s = 0; s < tbl[t].stall; s++) begin
                chk("stall_valid", 64'(sif.out_valid), 64'(1));
                chk("stall_index", 64'(sif.out_index), 64'(0));
                chk("stall_val", 64'(sif.out_val), 64'(tbl[t].vb[VW-1:0]));
                cycle();
            end
            sif.out_ready = 1'b1;
            for (int b = 0; b < NN; b++) begin
                chk("tbl_valid", 64'(sif.out_valid), 64'(1));
                chk("tbl_index", 64'(sif.out_index), 64'(b));
                chk("tbl_val", 64'(sif.out_val), 64'(tbl[t].vb[b*VW +: VW]));
                chk("tbl_pos", 64'(sif.out_pos), 64'(tbl[t].pb[b*PW +: PW]));
                chk("tbl_last", 64'(sif.out_last), 64'(b == NN - 1));
                chk("tbl_seq", 64'(sif.out_seq), 64'(tbl[t].exp_seq));
                cycle();
            end
            chk("tbl_idle", 64'(sif.out_valid), 64'(0));
            chk("tbl_overrun", 64'(sif.overrun), 64'(0));
        end

        // step_done on the final handshake is captured with no gap
        va  = {32'h111, 32'h110, 32'h100};
        pa  = {32'd12, 32'd11, 32'd10};
        vb2 = {32'h222, 32'h221, 32'h220};
        pb2 = {32'd22, 32'd21, 32'd20};
        sif.out_ready = 1'b1;
        pulse(va, pa);
        cycle();
        cycle();
        chk("bnd_last", 64'(sif.out_last), 64'(1));
        pulse(vb2, pb2);
        chk("bnd_valid", 64'(sif.out_valid), 64'(1));
        chk("bnd_index", 64'(sif.out_index), 64'(0));
        chk("bnd_val", 64'(sif.out_val), 64'(32'h220));
        chk("bnd_seq", 64'(sif.out_seq), 64'(5));
        chk("bnd_overrun", 64'(sif.overrun), 64'(0));
        drain_idle();

        // second (and third) capture into a stalled drain
        va = {32'h333, 32'h332, 32'h330};
        vb2 = {32'h444, 32'h442, 32'h440};
        vc = {32'h555, 32'h552, 32'h550};
        pc = {32'd3, 32'd2, 32'd1};
        sif.out_ready = 1'b0;
        pulse(va, pa);
        pulse(vb2, pb2);
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
        chk("ovr_dbl_clear", 64'(sif.overrun), 64'(0));
        pulse(vc, pc);
        chk("ovr_dbl_set", 64'(sif.overrun), 64'(1));
`else
        chk("ovr_single_set", 64'(sif.overrun), 64'(1));
`endif
        cycle();
        chk("ovr_hold_index", 64'(sif.out_index), 64'(0));
        chk("ovr_hold_val", 64'(sif.out_val), 64'(32'h330));
        sif.out_ready = 1'b1;
        cycle();
        cycle();
        cycle();
`ifdef NODE_SNAPSHOT_DOUBLE_BUFFER_EN
        chk("ovr_b2b_valid", 64'(sif.out_valid), 64'(1));
        chk("ovr_b2b_index", 64'(sif.out_index), 64'(0));
        chk("ovr_b2b_val", 64'(sif.out_val), 64'(32'h440));
        chk("ovr_b2b_seq", 64'(sif.out_seq), 64'(7));
        drain_idle();
`else
        chk("ovr_idle", 64'(sif.out_valid), 64'(0));
        pulse(vc, pc);
        chk("ovr_next_seq", 64'(sif.out_seq), 64'(7));
        chk("ovr_next_val", 64'(sif.out_val), 64'(32'h550));
        drain_idle();
`endif
        chk("ovr_sticky", 64'(sif.overrun), 64'(1));

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step = ($urandom_range(0, 5) == 0);
            vbus = rand_bus();
            pbus = rand_bus();
            sif.out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        step = 1'b0;
        drain_idle();

        // sequence number wrap
        force dut.seq_cnt_q = 16'hFFFF;
        #1;
        release dut.seq_cnt_q;
        mseq = 16'hFFFF;
        pulse(rand_bus(), rand_bus());
        chk("wrap_ffff", 64'(sif.out_seq), 64'(16'hFFFF));
        drain_idle();
        pulse(rand_bus(), rand_bus());
        chk("wrap_0000", 64'(sif.out_seq), 64'(16'h0000));
        drain_idle();

        // reset in the middle of a drain
        pulse(va, pa);
        cycle();
        chk("rst_mid_index", 64'(sif.out_index), 64'(1));
        rst_n = 1'b0;
        cycle();
        chk_reset_values("rst_mid");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rst_no_beats", 64'(sif.out_valid), 64'(0));
        end

        // decimation by 4: pulses 1 and 5 are captured
        for (int p = 1; p <= 8; p++) begin
            step_d = 1'b1;
            vbus_d = {32'(p + 200), 32'(p + 100), 32'(p)};
            pbus_d = rand_bus();
            cycle();
            step_d = 1'b0;
            for (int c = 0; c < NN + 2; c++) begin
                if (sif_d.out_valid && sif_d.out_index == '0) begin
                    got_val.push_back(sif_d.out_val);
                    got_seq.push_back(sif_d.out_seq);
                end
                cycle();
            end
        end
        chk("decim_count", 64'(got_val.size()), 64'(2));
        if (got_val.size() >= 2) begin
            chk("decim_first_val", 64'(got_val[0]), 64'(1));
            chk("decim_first_seq", 64'(got_seq[0]), 64'(0));
            chk("decim_second_val", 64'(got_val[1]), 64'(5));
            chk("decim_second_seq", 64'(got_seq[1]), 64'(1));
        end
        chk("decim_overrun", 64'(sif_d.overrun), 64'(0));
        chk("decim_idle", 64'(sif_d.out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/node_snapshot_unit.md
# node_snapshot_unit

Downstream readout stage for the 1-D node chain. On each completed timestep it captures the `nodeval`/`nodepos` outputs of all NUM_NODES node instances in one parallel snapshot. It then streams them out one node per beat over a valid/ready interface to the host/logging side. This decouples the free-running node array from a possibly stalling consumer and reports lost snapshots.

## Interface
Parameters:
- NUM_NODES, 3, number of node instances in the chain (≥2)
- VAL_W, 32, width of one `nodeval`
- POS_W, 32, width of one `nodepos`
- DECIM, 1, capture every DECIM-th timestep (≥1)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- step_done  in  1  one-cycle pulse: node array finished a timestep, `nodeval_bus`/`nodepos_bus` valid this cycle
- nodeval_bus  in  NUM_NODES*VAL_W  node i at bits [i*VAL_W +: VAL_W]
- nodepos_bus  in  NUM_NODES*POS_W  node i at bits [i*POS_W +: POS_W]
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_index  out  $clog2(NUM_NODES)  node index of current beat
- out_val  out  VAL_W  captured nodeval
- out_pos  out  POS_W  captured nodepos
- out_last  out  1  high on the beat with out_index == NUM_NODES-1
- out_seq  out  16  snapshot sequence number, same on all beats of one snapshot
- overrun  out  1  sticky, set when an eligible snapshot is dropped

## Operation
- Decimation counter `dcnt` (0..DECIM-1) advances on every step_done and wraps DECIM-1 → 0. A step_done is *eligible* when `dcnt == 0` before the increment.
- FSM states:
  - IDLE: out_valid=0. On eligible step_done, capture both buses into the active bank and go to DRAIN with index 0.
  - DRAIN: out_valid=1, and outputs come from the bank at the current index. On a handshake (out_valid && out_ready), index increments. A handshake with out_last high ends the snapshot: next state is IDLE, or DRAIN of the next snapshot if one is pending or captured this cycle.
- Eligible step_done while in DRAIN with no free bank: the snapshot is dropped, overrun is set, and `out_seq` is not advanced.
- Eligible step_done in the same cycle as the final (out_last) handshake is never dropped. It is captured and drained next, with index 0 and out_valid staying high.
- out_seq increments by 1 per captured (not dropped) snapshot and wraps 0xFFFF → 0x0000. The first snapshot after reset has seq 0.
- Non-eligible step_done has no effect besides advancing `dcnt`.
- overrun clears only on reset.
- Reset values: out_valid=0, out_index=0, out_val=0, out_pos=0, out_last=0, out_seq=0, overrun=0, `dcnt`=0, FSM=IDLE, banks cleared.
- Reset asserted mid-drain aborts the snapshot; no further beats of it appear.

## Timing
- Capture occurs at the clk edge where step_done=1. out_valid rises the next cycle, giving 1-cycle latency from step_done to the first beat.
- With out_ready held high, a snapshot drains in exactly NUM_NODES cycles.
- All out_* signals are registered.
- While out_valid && !out_ready, all out_* signals hold stable.
- out_valid never drops before the out_last handshake.
- Bus inputs are sampled only on eligible step_done cycles; at other times they are don't-care.

## Configuration
- `NODE_SNAPSHOT_DOUBLE_BUFFER_EN` defined:
  - A second bank is present.
  - Eligible step_done during DRAIN fills the free bank and marks it pending. Drain of the pending bank starts on the cycle after the current out_last handshake, with no gap (out_valid stays high).
  - overrun is set only if both banks are occupied.
  - A pending snapshot takes seq = current + 1.
- Undefined:
  - Single bank only.
  - Any eligible step_done during DRAIN, except on the final-handshake cycle, is dropped and sets overrun.

## Structure
- Shared package `node_pkg` holds:
  - default VAL_W/POS_W
  - the FSM state typedef (IDLE, DRAIN)
  - the SEQ_W=16 constant
- Sub-module `snapshot_bank`: one NUM_NODES-entry register bank with a parallel-load port and an indexed read mux. It is instantiated once, or twice under the macro.

## Test plan
- **Single snapshot:**
  - Stimulus: NUM_NODES=3, out_ready=1, step_done with vals {0x10,0x20,0x30}, pos {1,2,3}.
  - Response: beats at cycles +1..+3 with index 0,1,2, matching val/pos; out_last only on index 2; out_seq=0.
- **Backpressure:**
  - Stimulus: out_ready=0 for 5 cycles after capture, then 1.
  - Response: beat 0 held stable for 5 cycles; all 3 beats delivered in order; no overrun.
- **Overrun:**
  - Stimulus: second step_done 1 cycle into a stalled drain.
  - Response, macro off: overrun=1, next snapshot has seq 1 only after a later capture.
  - Response, macro on: second snapshot drains back-to-back with seq 1, overrun=0. A third step_done during the same stall sets overrun.
- **Boundary:**
  - Stimulus: step_done coincident with the out_last handshake.
  - Response: captured; out_valid stays high; next beat index 0 with the new data.
- **Decimation and wrap:**
  - Stimulus: DECIM=4 and 8 step_done pulses.
  - Response: exactly 2 snapshots, from pulses 1 and 5.
  - Stimulus: force seq to 0xFFFF.
  - Response: next snapshot seq 0x0000.
- **Reset mid-drain:**
  - Stimulus: rst_n=0 for 1 cycle at beat 1.
  - Response: all outputs return to their reset values the next cycle; no remaining beats appear.
